// File: rtl/tdm_demux_1to4.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux_1to4
//  Purpose  : Receive side of a TDM link. Locks onto the frame marker, steers
//             each serial beat into its channel slot and publishes complete
//             frames on a wide parallel bus.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux_1to4 #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    input  logic                     frame_sync,
    output logic [NCH*WIDTH-1:0]     dout,
    output logic                     frame_valid,
    output logic [$clog2(NCH)-1:0]   slot,
    output logic                     locked,
    output logic                     sync_err
);

    localparam int                 SW      = $clog2(NCH);
    localparam logic [SW-1:0]      c_LAST  = SW'(NCH - 1);
    localparam logic [SW-1:0]      c_ONE   = SW'(1);
    localparam logic [0:0]         c_HUNT  = 1'b0;
    localparam logic [0:0]         c_LOCK  = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [SW-1:0]          r_slot;
    logic [SW-1:0]          w_slot_nxt;
    logic [WIDTH-1:0]       r_shadow [NCH];
    logic [NCH*WIDTH-1:0]   r_dout;
    logic                   r_frame_valid;
    logic                   r_sync_err;
    logic                   r_locked;

    // Decisions taken for the current beat
    logic                   w_wr_en;
    logic [SW-1:0]          w_wr_idx;
    logic                   w_publish;
    logic                   w_err;

    // Registered output values for the next cycle
    logic                   w_fv_nxt;
    logic                   w_err_nxt;
    logic                   w_locked_nxt;
    logic [NCH*WIDTH-1:0]   w_frame;

    // State register: HUNT/LOCK and the slot pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_HUNT;
            r_slot  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    // Next-state logic: framing decisions for a valid beat, hold otherwise
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_slot;
        w_publish   = 1'b0;
        w_err       = 1'b0;
        if (din_valid) begin
            if (r_state == c_HUNT) begin
                if (frame_sync) begin
                    w_wr_en     = 1'b1;
                    w_wr_idx    = '0;
                    w_slot_nxt  = c_ONE;
                    w_state_nxt = c_LOCK;
                end
            end else begin
                if (frame_sync) begin
                    // A marker anywhere but slot 0 abandons the partial frame
                    // and restarts the frame on this beat.
                    w_err      = (r_slot != '0);
                    w_wr_en    = 1'b1;
                    w_wr_idx   = '0;
                    w_slot_nxt = c_ONE;
                end else if (r_slot == '0) begin
                    w_err       = 1'b1;
                    w_slot_nxt  = '0;
                    w_state_nxt = c_HUNT;
                end else if (r_slot == c_LAST) begin
                    w_publish  = 1'b1;
                    w_slot_nxt = '0;
                end else begin
                    w_wr_en    = 1'b1;
                    w_slot_nxt = r_slot + c_ONE;
                end
            end
        end
    end

    // Output logic: next values of the registered status outputs
    always_comb begin
        w_fv_nxt     = w_publish;
        w_err_nxt    = w_err;
        w_locked_nxt = (w_state_nxt == c_LOCK);
    end

    // Frame assembly: shadow slots plus the last beat taken straight from din
    always_comb begin
        w_frame = '0;
        for (int k = 0; k < NCH - 1; k++) begin
            w_frame[k*WIDTH +: WIDTH] = r_shadow[k];
        end
        w_frame[(NCH-1)*WIDTH +: WIDTH] = din;
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                r_shadow[k] <= '0;
            end
            r_dout        <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_shadow[w_wr_idx] <= din;
            end
            if (w_publish) begin
                r_dout <= w_frame;
            end
            r_frame_valid <= w_fv_nxt;
            r_sync_err    <= w_err_nxt;
            r_locked      <= w_locked_nxt;
        end
    end

    assign dout        = r_dout;
    assign frame_valid = r_frame_valid;
    assign slot        = r_slot;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_1to4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux_1to4
//  Purpose  : Directed self-checking bench for tdm_demux_1to4 (NCH=4, WIDTH=4)
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux_1to4;

    logic        clk;
    logic        rst;
    logic [3:0]  din;
    logic        din_valid;
    logic        frame_sync;
    logic [15:0] dout;
    logic        frame_valid;
    logic [1:0]  slot;
    logic        locked;
    logic        sync_err;

    int n_tests;
    int n_fail;

    tdm_demux_1to4 #(.WIDTH(4), .NCH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then settle just after the clock edge
    task automatic step(input logic v, input logic [3:0] d, input logic s);
        @(negedge clk);
        din_valid  = v;
        din        = d;
        frame_sync = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        din        = 4'h0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;

        // 1. Reset for two cycles, then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 4'h0, 1'b0);
        chk("t1_dout",   32'(dout), 32'h0);
        chk("t1_fv",     32'(frame_valid), 32'h0);
        chk("t1_locked", 32'(locked), 32'h0);
        chk("t1_slot",   32'(slot), 32'h0);
        chk("t1_serr",   32'(sync_err), 32'h0);

        // 2. Back-to-back frame A,B,C,D
        step(1'b1, 4'hA, 1'b1);
        chk("t2_locked_a", 32'(locked), 32'h1);
        chk("t2_slot_a",   32'(slot), 32'h1);
        step(1'b1, 4'hB, 1'b0);
        step(1'b1, 4'hC, 1'b0);
        chk("t2_fv_c",     32'(frame_valid), 32'h0);
        step(1'b1, 4'hD, 1'b0);
        chk("t2_fv",       32'(frame_valid), 32'h1);
        chk("t2_dout",     32'(dout), 32'hDCBA);
        chk("t2_slot",     32'(slot), 32'h0);
        chk("t2_locked",   32'(locked), 32'h1);
        chk("t2_serr",     32'(sync_err), 32'h0);
        step(1'b0, 4'h0, 1'b0);
        chk("t2_fv_drop",  32'(frame_valid), 32'h0);
        chk("t2_dout_hold", 32'(dout), 32'hDCBA);

        // 3. Gap mid-frame; frame_sync without din_valid is ignored
        step(1'b1, 4'h1, 1'b1);
        step(1'b1, 4'h2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'hE, 1'b1);
            chk("t3_gap_slot", 32'(slot), 32'h2);
            chk("t3_gap_fv",   32'(frame_valid), 32'h0);
            chk("t3_gap_serr", 32'(sync_err), 32'h0);
        end
        step(1'b1, 4'h3, 1'b0);
        chk("t3_fv_3",  32'(frame_valid), 32'h0);
        step(1'b1, 4'h4, 1'b0);
        chk("t3_fv",    32'(frame_valid), 32'h1);
        chk("t3_dout",  32'(dout), 32'h4321);
        step(1'b0, 4'h0, 1'b0);
        chk("t3_fv_drop", 32'(frame_valid), 32'h0);

        // 4. Early marker discards the partial frame and restarts
        step(1'b1, 4'h5, 1'b1);
        step(1'b1, 4'h6, 1'b0);
        step(1'b1, 4'h7, 1'b1);
        chk("t4_serr",      32'(sync_err), 32'h1);
        chk("t4_fv_early",  32'(frame_valid), 32'h0);
        chk("t4_dout_hold", 32'(dout), 32'h4321);
        chk("t4_slot",      32'(slot), 32'h1);
        chk("t4_locked",    32'(locked), 32'h1);
        step(1'b1, 4'h8, 1'b0);
        chk("t4_serr_drop", 32'(sync_err), 32'h0);
        step(1'b1, 4'h9, 1'b0);
        chk("t4_dout_hold2", 32'(dout), 32'h4321);
        step(1'b1, 4'hA, 1'b0);
        chk("t4_fv",   32'(frame_valid), 32'h1);
        chk("t4_dout", 32'(dout), 32'hA987);
        chk("t4_serr_fv", 32'(sync_err), 32'h0);

        // 5. Missing marker at slot 0 drops lock; unsynced beats ignored
        step(1'b1, 4'hF, 1'b0);
        chk("t5_serr",   32'(sync_err), 32'h1);
        chk("t5_locked", 32'(locked), 32'h0);
        chk("t5_slot",   32'(slot), 32'h0);
        chk("t5_fv",     32'(frame_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'(i + 5), 1'b0);
            chk("t5_hunt_locked", 32'(locked), 32'h0);
            chk("t5_hunt_slot",   32'(slot), 32'h0);
            chk("t5_hunt_serr",   32'(sync_err), 32'h0);
        end
        chk("t5_dout_hold", 32'(dout), 32'hA987);
        step(1'b1, 4'h1, 1'b1);
        chk("t5_relock", 32'(locked), 32'h1);
        step(1'b1, 4'h2, 1'b0);
        step(1'b1, 4'h3, 1'b0);
        step(1'b1, 4'h4, 1'b0);
        chk("t5_fv",   32'(frame_valid), 32'h1);
        chk("t5_dout", 32'(dout), 32'h4321);

        // 6. Reset mid-frame clears everything
        step(1'b1, 4'h5, 1'b1);
        step(1'b1, 4'h6, 1'b0);
        chk("t6_slot_pre", 32'(slot), 32'h2);
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_dout",   32'(dout), 32'h0);
        chk("t6_slot",   32'(slot), 32'h0);
        chk("t6_locked", 32'(locked), 32'h0);
        chk("t6_fv",     32'(frame_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 4'h7, 1'b0);
        step(1'b1, 4'h8, 1'b0);
        chk("t6_post_fv",     32'(frame_valid), 32'h0);
        chk("t6_post_locked", 32'(locked), 32'h0);
        chk("t6_post_dout",   32'(dout), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
